// File: rtl/seq_multiplier_if.sv
// Request/response bundle for the iterative multiplier.
// The controller drives it through the master modport, and the multiplier responds through the slave modport.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;

  modport master (
    output start_i, signed_i, src1_i, src2_i,
    input  busy_o, done_o, result_o, result_hi_o
  );

  modport slave (
    input  start_i, signed_i, src1_i, src2_i,
    output busy_o, done_o, result_o, result_hi_o
  );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier that performs one partial product per clock.
// It works on operand magnitudes and applies the sign to the full 2*WIDTH product at the end.
// Latency is a constant WIDTH cycles, and there is no early termination on zero operands.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  seq_multiplier_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] mcand;     // multiplicand, pre-shifted by the current step
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [CW-1:0]      count;
  logic               neg;
  logic               accept;
  logic               last;

  // Negating the most negative value in WIDTH bits yields 2^(WIDTH-1) read as unsigned, which is the correct magnitude.
  assign mag1    = (bus.signed_i && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
  assign mag2    = (bus.signed_i && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;
  assign accept  = bus.start_i && (state != RUN);
  assign last    = (state == RUN) && (count == CW'(WIDTH - 1));
  assign acc_sum = mplier[0] ? acc + mcand : acc;

  assign bus.result_o    = prod[WIDTH-1:0];
  assign bus.result_hi_o = prod[2*WIDTH-1:WIDTH];

  // State register; reset aborts any in-flight multiply.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_next  = state;
    bus.busy_o  = 1'b0;
    bus.done_o  = 1'b0;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        bus.busy_o = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_next = bus.start_i ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, run one shift-add step per RUN cycle, and register the signed product on the last step.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      prod   <= '0;
    end else begin
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, mag1};
        mplier <= mag2;
        acc    <= '0;
        count  <= '0;
        neg    <= bus.signed_i & (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
      end else if (state == RUN) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
      if (last) prod <= neg ? -acc_sum : acc_sum;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=32.
// A cycle-level model built on plain 64-bit arithmetic runs alongside the DUT.
// A compare process checks all outputs on every falling edge, and directed sequences add literal expectations.
module tb_seq_multiplier;
  localparam int WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Model: a start is accepted whenever no multiply is counting down.
  // Outputs follow WIDTH cycles later.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pending = '0;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_prod <= m_pending;
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start_i) begin
        m_left    <= WIDTH;
        m_pending <= ref_product(bus.signed_i, bus.src1_i, bus.src2_i);
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("busy", 64'(bus.busy_o), 64'(m_left != 0));
      check("done", 64'(bus.done_o), 64'(m_done));
      check("product", {bus.result_hi_o, bus.result_o}, m_prod);
    end
  end

  // Drives a one-cycle start; returns in the middle of cycle 1.
  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    bus.start_i  = 1'b1;
    bus.signed_i = s;
    bus.src1_i   = a;
    bus.src2_i   = b;
    @(negedge clk_i);
    bus.start_i  = 1'b0;
  endtask

  // Counts cycles from the current one (cyc starts at 'from') until done_o, bounded.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!bus.done_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  int cyc;
  int extra_done;

  initial begin
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.src1_i   = '0;
    bus.src2_i   = '0;
    repeat (2) @(posedge clk_i);
    cmp_en = 1'b1;
    @(negedge clk_i);
    check("reset_outputs", {30'd0, bus.busy_o, bus.done_o, bus.result_hi_o}, 64'd0);
    check("reset_result", 64'(bus.result_o), 64'd0);
    rst_i = 1'b1;

    // Unsigned 7*6: busy from cycle 1, done exactly in cycle 33
    do_start(1'b0, 32'd7, 32'd6);
    check("t1_busy_c1", 64'(bus.busy_o), 64'd1);
    wait_done(1, cyc);
    check("t1_done_cycle", 64'(cyc), 64'd33);
    check("t1_lo", 64'(bus.result_o), 64'h2A);
    check("t1_hi", 64'(bus.result_hi_o), 64'h0);

    // Signed products
    do_start(1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, cyc);
    check("t2_neg3x5", {bus.result_hi_o, bus.result_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_start(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done(1, cyc);
    check("t2_minxmin", {bus.result_hi_o, bus.result_o}, 64'h4000_0000_0000_0000);

    // All-ones operands, unsigned then signed
    do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc);
    check("t3_unsigned_ones", {bus.result_hi_o, bus.result_o}, 64'hFFFF_FFFE_0000_0001);
    do_start(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc);
    check("t3_signed_ones", {bus.result_hi_o, bus.result_o}, 64'h0000_0000_0000_0001);

    // A start pulse during RUN is ignored
    do_start(1'b0, 32'd100, 32'd200);
    repeat (9) @(negedge clk_i);
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b1;
    bus.src1_i   = 32'd3;
    bus.src2_i   = 32'hFFFF_FFFF;
    @(negedge clk_i);
    bus.start_i  = 1'b0;
    wait_done(11, cyc);
    check("t4_done_cycle", 64'(cyc), 64'd33);
    check("t4_result", {bus.result_hi_o, bus.result_o}, 64'd20000);
    extra_done = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (bus.done_o || bus.busy_o) extra_done++;
    end
    check("t4_idle_after", 64'(extra_done), 64'd0);

    // Reset mid-run aborts the multiply and clears outputs
    do_start(1'b0, 32'd9, 32'd9);
    repeat (14) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t5_reset_clear", {31'd0, bus.busy_o, bus.done_o, bus.result_hi_o}, 64'd0);
    check("t5_reset_lo", 64'(bus.result_o), 64'd0);
    rst_i = 1'b1;
    extra_done = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.done_o) extra_done++;
    end
    check("t5_no_done", 64'(extra_done), 64'd0);
    do_start(1'b0, 32'd11, 32'd13);
    wait_done(1, cyc);
    check("t5_after_reset", {bus.result_hi_o, bus.result_o}, 64'd143);

    // Back-to-back: start held high through the DONE cycle
    @(negedge clk_i);
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.src1_i   = 32'd7;
    bus.src2_i   = 32'd6;
    @(negedge clk_i);
    bus.src1_i   = 32'd3;
    bus.src2_i   = 32'd4;
    wait_done(1, cyc);
    check("t6_first_cycle", 64'(cyc), 64'd33);
    check("t6_first", {bus.result_hi_o, bus.result_o}, 64'd42);
    @(negedge clk_i);
    bus.start_i = 1'b0;
    check("t6_busy_c34", 64'(bus.busy_o), 64'd1);
    check("t6_hold_42", {bus.result_hi_o, bus.result_o}, 64'd42);
    wait_done(34, cyc);
    check("t6_second_cycle", 64'(cyc), 64'd66);
    check("t6_second", {bus.result_hi_o, bus.result_o}, 64'd12);

    repeat (3) @(negedge clk_i);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
